// File: rtl/fibonacci_pkg.sv
// Shared definitions for the Fibonacci sequence generator: state encoding,
// default widths and the seed pair that starts every sequence.
package fibonacci_pkg;

    localparam int unsigned FIB_VAL_WIDTH   = 30;
    localparam int unsigned FIB_CLOCK_WIDTH = 6;

    localparam int unsigned FIB_SEED_A = 0;
    localparam int unsigned FIB_SEED_B = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } fib_state_e;

endpackage

// File: rtl/fib_prescaler.sv
// Step-period divider: raises tick once every clock_op enabled cycles.
// A zero period holds the count so the sequence freezes in place.
module fib_prescaler
    import fibonacci_pkg::*;
#(
    parameter int unsigned CLOCK_WIDTH = FIB_CLOCK_WIDTH
) (
    input  logic                   wb_clk_i,
    input  logic                   reset,
    input  logic                   count_en,
    input  logic                   clear,
    input  logic [CLOCK_WIDTH-1:0] clock_op,
    output logic                   tick
);

    localparam logic [CLOCK_WIDTH-1:0] CNT_ZERO = CLOCK_WIDTH'(0);
    localparam logic [CLOCK_WIDTH-1:0] CNT_ONE  = CLOCK_WIDTH'(1);

    logic [CLOCK_WIDTH-1:0] div_cnt_q;
    logic [CLOCK_WIDTH-1:0] div_cnt_d;

    // A period shortened below the current count fires on the next cycle
    // instead of letting the counter run round.
    always_comb begin
        if (count_en && (clock_op != CNT_ZERO) && (div_cnt_q >= (clock_op - CNT_ONE))) begin
            tick = 1'b1;
        end else begin
            tick = 1'b0;
        end
    end

    // Next count value.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clear) begin
            div_cnt_d = CNT_ZERO;
        end else if (!count_en || (clock_op == CNT_ZERO)) begin
            div_cnt_d = div_cnt_q;
        end else if (tick) begin
            div_cnt_d = CNT_ZERO;
        end else begin
            div_cnt_d = div_cnt_q + CNT_ONE;
        end
    end

    // Count register.
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            div_cnt_q <= CNT_ZERO;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/fibonacci_core.sv
// Free-running Fibonacci generator with pause/resume, programmable step
// period and automatic restart once the next term no longer fits VAL_WIDTH.
module fibonacci_core
    import fibonacci_pkg::*;
#(
    parameter int unsigned CLOCK_WIDTH = FIB_CLOCK_WIDTH,
    parameter int unsigned VAL_WIDTH   = FIB_VAL_WIDTH
) (
    input  logic                   wb_clk_i,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [CLOCK_WIDTH-1:0] clock_op,
    output logic [VAL_WIDTH-1:0]   fib_out,
    output logic                   fib_valid,
    output logic                   wrap_irq,
    output logic                   running
);

    localparam logic [VAL_WIDTH-1:0] VAL_ZERO = VAL_WIDTH'(0);
    localparam logic [VAL_WIDTH-1:0] A_SEED   = VAL_WIDTH'(FIB_SEED_A);
    localparam logic [VAL_WIDTH-1:0] B_SEED   = VAL_WIDTH'(FIB_SEED_B);

    fib_state_e           state_q, state_d;
    logic [VAL_WIDTH-1:0] a_q, a_d;
    logic [VAL_WIDTH-1:0] b_q, b_d;
    logic [VAL_WIDTH-1:0] fib_out_q, fib_out_d;
    logic                 wrap_pending_q, wrap_pending_d;
    logic                 fib_valid_q, fib_valid_d;
    logic                 wrap_irq_q, wrap_irq_d;
    logic                 running_q, running_d;

    logic [VAL_WIDTH:0]   sum_s;
    logic                 tick_s;
    logic                 count_en_s;
    logic                 clear_s;

    assign sum_s = {1'b0, a_q} + {1'b0, b_q};

    fib_prescaler #(
        .CLOCK_WIDTH (CLOCK_WIDTH)
    ) u_prescaler (
        .wb_clk_i (wb_clk_i),
        .reset    (reset),
        .count_en (count_en_s),
        .clear    (clear_s),
        .clock_op (clock_op),
        .tick     (tick_s)
    );

    // Control state machine; the prescaler restarts on seeding and on pausing.
    always_comb begin
        state_d    = state_q;
        count_en_s = 1'b0;
        clear_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SEED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEED: begin
                state_d = ST_RUN;
                clear_s = 1'b1;
            end
            ST_RUN: begin
                count_en_s = 1'b1;
                if (!enable) begin
                    state_d = ST_PAUSE;
                    clear_s = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Term datapath. After a carry, b holds a truncated sum that is never
    // shown; the following tick outputs 0 and reseeds instead.
    always_comb begin
        a_d            = a_q;
        b_d            = b_q;
        fib_out_d      = fib_out_q;
        wrap_pending_d = wrap_pending_q;
        fib_valid_d    = 1'b0;
        wrap_irq_d     = 1'b0;
        case (state_q)
            ST_SEED: begin
                a_d            = A_SEED;
                b_d            = B_SEED;
                fib_out_d      = A_SEED;
                wrap_pending_d = 1'b0;
            end
            ST_RUN: begin
                if (tick_s && wrap_pending_q) begin
                    a_d            = A_SEED;
                    b_d            = B_SEED;
                    fib_out_d      = VAL_ZERO;
                    wrap_pending_d = 1'b0;
                    fib_valid_d    = 1'b1;
                    wrap_irq_d     = 1'b1;
                end else if (tick_s) begin
                    a_d            = b_q;
                    b_d            = sum_s[VAL_WIDTH-1:0];
                    fib_out_d      = b_q;
                    wrap_pending_d = sum_s[VAL_WIDTH];
                    fib_valid_d    = 1'b1;
                end else begin
                    fib_valid_d    = 1'b0;
                end
            end
            default: begin
                fib_valid_d = 1'b0;
            end
        endcase
        running_d = (state_d == ST_RUN);
    end

    // State and datapath registers.
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            a_q            <= VAL_ZERO;
            b_q            <= VAL_ZERO;
            fib_out_q      <= VAL_ZERO;
            wrap_pending_q <= 1'b0;
            fib_valid_q    <= 1'b0;
            wrap_irq_q     <= 1'b0;
            running_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            fib_out_q      <= fib_out_d;
            wrap_pending_q <= wrap_pending_d;
            fib_valid_q    <= fib_valid_d;
            wrap_irq_q     <= wrap_irq_d;
            running_q      <= running_d;
        end
    end

    assign fib_out   = fib_out_q;
    assign fib_valid = fib_valid_q;
    assign wrap_irq  = wrap_irq_q;
    assign running   = running_q;

endmodule

// File: tb/tb_fibonacci_core.sv
// Bench for fibonacci_core: an 8-bit and a 30-bit instance share stimulus and
// are compared every cycle against a term-table model of the sequence.
module tb_fibonacci_core;

    logic        wb_clk_i = 1'b0;
    logic        reset    = 1'b1;
    logic        enable   = 1'b0;
    logic [5:0]  clock_op = 6'd0;

    logic [7:0]  fib8;
    logic        valid8, irq8, run8;
    logic [29:0] fib30;
    logic        valid30, irq30, run30;

    int n_cmp = 0;
    int n_err = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    fibonacci_core #(.CLOCK_WIDTH(6), .VAL_WIDTH(8)) dut_w8 (
        .wb_clk_i  (wb_clk_i),
        .reset     (reset),
        .enable    (enable),
        .clock_op  (clock_op),
        .fib_out   (fib8),
        .fib_valid (valid8),
        .wrap_irq  (irq8),
        .running   (run8)
    );

    fibonacci_core dut_w30 (
        .wb_clk_i  (wb_clk_i),
        .reset     (reset),
        .enable    (enable),
        .clock_op  (clock_op),
        .fib_out   (fib30),
        .fib_valid (valid30),
        .wrap_irq  (irq30),
        .running   (run30)
    );

    // Reference: the full list of representable terms per width, an index
    // into it, and the step-period phase.
    typedef enum {M_IDLE, M_SEED, M_RUN, M_PAUSE} mode_t;
    longint unsigned term8[$];
    longint unsigned term30[$];
    mode_t mode = M_IDLE;
    int    cnt = 0;
    int    k8 = 0;
    int    k30 = 0;
    bit    exp_valid = 1'b0;
    bit    exp_irq8 = 1'b0;
    bit    exp_irq30 = 1'b0;
    bit    exp_run = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic build_terms(input longint unsigned limit, output longint unsigned q[$]);
        longint unsigned x, y, z;
        q = {};
        x = 0;
        y = 1;
        while (x < limit) begin
            q.push_back(x);
            z = x + y;
            x = y;
            y = z;
        end
    endtask

    task automatic model_update();
        exp_valid = 1'b0;
        exp_irq8  = 1'b0;
        exp_irq30 = 1'b0;
        if (reset) begin
            mode = M_IDLE;
            k8   = 0;
            k30  = 0;
            cnt  = 0;
        end else begin
            case (mode)
                M_IDLE: if (enable) mode = M_SEED;
                M_SEED: begin
                    k8   = 0;
                    k30  = 0;
                    cnt  = 0;
                    mode = M_RUN;
                end
                M_RUN: begin
                    if (clock_op != 0 && cnt + 1 >= int'(clock_op)) begin
                        k8        = (k8 + 1) % term8.size();
                        k30       = (k30 + 1) % term30.size();
                        exp_valid = 1'b1;
                        exp_irq8  = (k8 == 0);
                        exp_irq30 = (k30 == 0);
                        cnt       = 0;
                    end else if (clock_op != 0) begin
                        cnt++;
                    end
                    if (!enable) begin
                        mode = M_PAUSE;
                        cnt  = 0;
                    end
                end
                M_PAUSE: if (enable) mode = M_RUN;
                default: mode = M_IDLE;
            endcase
        end
        exp_run = (mode == M_RUN);
    endtask

    task automatic step(input logic r, input logic e, input logic [5:0] op);
        reset    = r;
        enable   = e;
        clock_op = op;
        @(posedge wb_clk_i);
        model_update();
        #1;
        check_eq("fib8",    fib8,    term8[k8]);
        check_eq("fib30",   fib30,   term30[k30]);
        check_eq("valid8",  valid8,  exp_valid);
        check_eq("valid30", valid30, exp_valid);
        check_eq("irq8",    irq8,    exp_irq8);
        check_eq("irq30",   irq30,   exp_irq30);
        check_eq("run8",    run8,    exp_run);
        check_eq("run30",   run30,   exp_run);
    endtask

    initial begin
        int seq028[6]  = '{1, 1, 2, 3, 5, 8};
        int seq029[16] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 0, 1, 1};
        int restart[3] = '{1, 1, 2};
        logic       en_r;
        logic [5:0] op_r;
        int         sel;

        build_terms(64'd256, term8);
        build_terms(64'd1073741824, term30);

        step(1'b1, 1'b0, 6'd0);
        step(1'b1, 1'b0, 6'd0);
        check_eq("rst_fib30", fib30, 64'd0);
        check_eq("rst_valid", valid30, 64'd0);
        check_eq("rst_run",   run30, 64'd0);

        // Back-to-back terms with a one-cycle step.
        step(1'b0, 1'b1, 6'd1);
        step(1'b0, 1'b1, 6'd1);
        check_eq("seed_fib", fib30, 64'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 6'd1);
            check_eq("seq_fib",   fib30,   64'(seq028[i]));
            check_eq("seq_valid", valid30, 64'd1);
        end

        // Dropping enable on a tick cycle still lands 13, then holds.
        step(1'b0, 1'b0, 6'd1);
        check_eq("pause_tick", fib30, 64'd13);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 6'd1);
            check_eq("pause_hold",  fib30,   64'd13);
            check_eq("pause_run",   run30,   64'd0);
            check_eq("pause_valid", valid30, 64'd0);
        end
        step(1'b0, 1'b1, 6'd1);
        step(1'b0, 1'b1, 6'd1);
        check_eq("resume_21", fib30, 64'd21);
        step(1'b0, 1'b1, 6'd1);
        check_eq("resume_34", fib30, 64'd34);
        step(1'b0, 1'b1, 6'd1);
        check_eq("pre_rst_55", fib30, 64'd55);

        // Reset mid-run, then a fresh sequence.
        step(1'b1, 1'b1, 6'd1);
        check_eq("midrst_fib30", fib30, 64'd0);
        check_eq("midrst_fib8",  fib8,  64'd0);
        check_eq("midrst_run",   run30, 64'd0);
        step(1'b0, 1'b1, 6'd1);
        step(1'b0, 1'b1, 6'd1);
        check_eq("restart_0", fib30, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 6'd1);
            check_eq("restart_seq", fib30, 64'(restart[i]));
        end

        // 8-bit wrap through 233 -> 0 with the interrupt on the zero.
        step(1'b1, 1'b0, 6'd1);
        step(1'b0, 1'b1, 6'd1);
        step(1'b0, 1'b1, 6'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 6'd1);
            check_eq("wrap8_fib", fib8, 64'(seq029[i]));
            check_eq("wrap8_irq", irq8, (i == 13) ? 64'd1 : 64'd0);
        end
        // Long enough for the 30-bit instance to wrap as well.
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 6'd1);

        // Period of 4 from a fresh seed.
        step(1'b1, 1'b0, 6'd4);
        step(1'b0, 1'b1, 6'd4);
        step(1'b0, 1'b1, 6'd4);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 6'd4);
            check_eq("op4_valid", valid30, (i % 4 == 3) ? 64'd1 : 64'd0);
        end

        // Shortening the period below the running count fires at once.
        step(1'b1, 1'b0, 6'd8);
        step(1'b0, 1'b1, 6'd8);
        step(1'b0, 1'b1, 6'd8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'd8);
        step(1'b0, 1'b1, 6'd2);
        check_eq("op_shrink_tick", valid30, 64'd1);
        step(1'b0, 1'b1, 6'd2);
        check_eq("op2_gap", valid30, 64'd0);
        step(1'b0, 1'b1, 6'd2);
        check_eq("op2_tick", valid30, 64'd1);

        // Zero period freezes while still running.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 6'd0);
            check_eq("hold_run", run30, 64'd1);
        end

        en_r = 1'b1;
        op_r = 6'd1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) en_r = ~en_r;
            if ($urandom_range(0, 39) == 0) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0:       op_r = 6'd0;
                    1:       op_r = 6'($urandom_range(1, 3));
                    2:       op_r = 6'd63;
                    default: op_r = 6'($urandom_range(1, 63));
                endcase
            end
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, en_r, op_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
